// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared BCD digit type and active-low 7-segment patterns
//
// Purpose : types, segment constants and helpers shared by the BCD counter
//           and the seven-segment decoder.
// Contents: bcd_digit_t, SEG_0..SEG_9, SEG_BLANK, BCD_MAX_DIGIT,
//           bcd_sanitize() (invalid digit -> 0).

package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal codes (A..F) are forced to zero so the counter never
    // holds an illegal BCD digit.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD digit to active-low 7-segment decoder
//
// Purpose : map one BCD digit onto the {g,f,e,d,c,b,a} segment pattern.
// Ports   : digit_i  in  4  BCD digit (values above 9 are shown blank)
//           seg_o    out 7  active-low segment pattern

module seg7_decoder
    import display_pkg::*;
(
    input  bcd_digit_t  digit_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - tick-driven BCD up/down counter with multiplexed 7-segment scan
//
// Purpose : NDIG-digit BCD counter advanced by the divider tick, plus a
//           free-running scanner that multiplexes the digits onto one
//           7-segment driver.
// Ports   : clk       in   1        system clock
//           rst       in   1        asynchronous active-high reset
//           tick      in   1        count strobe (counts every cycle it is high)
//           en        in   1        count enable
//           up        in   1        1 = increment, 0 = decrement
//           clr       in   1        synchronous clear (highest priority)
//           load      in   1        synchronous load of load_val
//           load_val  in   4*NDIG   BCD load value, digit 0 in [3:0]
//           bcd       out  4*NDIG   current count, digit 0 in [3:0]
//           wrap      out  1        one-cycle pulse after a roll-over
//           seg       out  7        {g,f,e,d,c,b,a}, active-low
//           an        out  NDIG     digit anodes, active-low, an[0] = LSD

module tick_bcd_counter
    import display_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int REFRESH_COUNT = 100_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*NDIG-1:0]   load_val,
    output logic [4*NDIG-1:0]   bcd,
    output logic                wrap,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an
);

    localparam int RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NDIG - 1);

    // ------------------------------------------------------------------
    // Counter state
    // ------------------------------------------------------------------
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic              wrap_q, wrap_d;
    logic [4*NDIG-1:0] step_val;
    logic [4*NDIG-1:0] load_clean;
    logic [NDIG-1:0]   at_lim;

    // Each digit moves when every lower digit sits at its limit (9 going up,
    // 0 going down). Evaluating the carry as a mask-AND rather than a rippled
    // chain keeps the per-digit logic independent of its neighbours' outputs.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit_t      cur;
        bcd_digit_t      nxt;
        logic            carry_in;
        logic [NDIG-1:0] lower_mask;

        assign cur        = bcd_q[4*g +: 4];
        assign at_lim[g]  = up ? (cur == BCD_MAX_DIGIT) : (cur == 4'd0);
        assign lower_mask = NDIG'((1 << g) - 1);
        assign carry_in   = &(at_lim | ~lower_mask);

        always_comb begin
            nxt = cur;
            if (carry_in) begin
                if (up) begin
                    nxt = (cur == BCD_MAX_DIGIT) ? 4'd0 : cur + 4'd1;
                end else begin
                    nxt = (cur == 4'd0) ? BCD_MAX_DIGIT : cur - 4'd1;
                end
            end
        end

        assign step_val[4*g +: 4]   = nxt;
        assign load_clean[4*g +: 4] = bcd_sanitize(load_val[4*g +: 4]);
    end

    // clr > load > (tick & en) > hold; wrap only ever follows a counting tick.
    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (clr) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = load_clean;
        end else if (tick && en) begin
            bcd_d  = step_val;
            wrap_d = &at_lim;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scanner
    // ------------------------------------------------------------------
    logic [RW-1:0]   refresh_q, refresh_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    bcd_digit_t      sel_digit;
    logic [6:0]      sel_seg;
    logic            refresh_done;

    assign refresh_done = (refresh_q == REFRESH_LAST);

    always_comb begin
        refresh_d = refresh_done ? '0 : refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_done) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign sel_digit = bcd_q[4*idx_q +: 4];

    seg7_decoder u_seg7_decoder (
        .digit_i (sel_digit),
        .seg_o   (sel_seg)
    );

    // an and seg are both registered from the same idx_q, so the lit anode
    // and its pattern always change on the same edge.
    always_comb begin
        an_d  = ~(NDIG'(1) << idx_q);
        seg_d = sel_seg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bcd  = bcd_q;
    assign wrap = wrap_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule
